// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one instruction-memory request
// in flight, and hands {pc_o, inst_o, inst_valid_o} to the IF/ID register.
module if_fetch_unit #(
    parameter int                 ADDR_W       = 64,
    parameter int                 INST_W       = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC     = 64'h8000_0000,
    parameter int                 CTRL_W       = 3,
    parameter logic [CTRL_W-1:0]  CTRL_STALLED = 3'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] ctrl_signal_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_gnt_i,
    input  logic              imem_rvalid_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              inst_valid_o
);

    // Memory handshake: a request transfers on a cycle where imem_req_o & imem_gnt_i;
    // the response is the first imem_rvalid_i seen in S_WAIT. Downstream has no ready:
    // a stall code on ctrl_signal_i means "do not overwrite pc_o/inst_o this cycle".
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;
    logic              kill_q, kill_d;
    logic [ADDR_W-1:0] skid_pc_q, skid_pc_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;

    logic              stall;
    logic [ADDR_W-1:0] fetch_pc_next;

    assign stall         = (ctrl_signal_i == CTRL_STALLED);
    assign fetch_pc_next = fetch_pc_q + ADDR_W'(4);

    assign imem_addr_o  = fetch_pc_q;
    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q  <= RESET_PC;
            pc_q        <= '0;
            inst_q      <= '0;
            valid_q     <= 1'b0;
            kill_q      <= 1'b0;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            valid_q     <= valid_d;
            kill_q      <= kill_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        // A held instruction survives stalled edges; otherwise it has been consumed.
        valid_d     = stall ? valid_q : 1'b0;
        kill_d      = kill_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        imem_req_o  = (state_q == S_REQ);

        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            valid_d    = 1'b0;
            unique case (state_q)
                S_REQ: begin
                    // A grant this cycle already launched the old address; its data must be killed.
                    if (imem_gnt_i) begin
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        kill_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_REQ;
                end
                S_REQ: begin
                    if (imem_gnt_i) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_REQ;
                        end else if (!stall) begin
                            pc_d       = fetch_pc_q;
                            inst_d     = imem_rdata_i;
                            valid_d    = 1'b1;
                            fetch_pc_d = fetch_pc_next;
                            state_d    = S_REQ;
                        end else begin
                            skid_pc_d   = fetch_pc_q;
                            skid_inst_d = imem_rdata_i;
                            fetch_pc_d  = fetch_pc_next;
                            state_d     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        pc_d    = skid_pc_q;
                        inst_d  = skid_inst_q;
                        valid_d = 1'b1;
                        state_d = S_REQ;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a hand-driven memory responder, a delivery scoreboard
// and point checks on the request/delivery ports.
module tb_if_fetch_unit;

    localparam int ADDR_W = 64;
    localparam int INST_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        ctrl_signal = 3'd0;
    logic              redirect = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt = 1'b0;
    logic              imem_rvalid = 1'b0;
    logic [INST_W-1:0] imem_rdata = '0;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              inst_valid;

    int checks   = 0;
    int failures = 0;
    logic [ADDR_W+INST_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    if_fetch_unit #(
        .ADDR_W      (ADDR_W),
        .INST_W      (INST_W),
        .RESET_PC    (64'h8000_0000),
        .CTRL_W      (3),
        .CTRL_STALLED(3'd1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl_signal_i(ctrl_signal),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_gnt_i   (imem_gnt),
        .imem_rvalid_i(imem_rvalid),
        .imem_rdata_i (imem_rdata),
        .pc_o         (pc),
        .inst_o       (inst),
        .inst_valid_o (inst_valid)
    );

    function automatic logic [INST_W-1:0] data_of(input logic [ADDR_W-1:0] a);
        return a[31:0] ^ 32'h1357_9bdf;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starting in S_REQ at address a: grant, return data one cycle later, expect delivery.
    task automatic serve(input logic [ADDR_W-1:0] a);
        imem_gnt = 1'b1;
        chk("req_addr", imem_addr, a);
        chk("req_valid", {63'd0, imem_req}, 64'd1);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = data_of(a);
        exp_q.push_back({a, data_of(a)});
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        chk("dlv_pc", pc, a);
        chk("dlv_inst", {32'd0, inst}, {32'd0, data_of(a)});
        chk("dlv_valid", {63'd0, inst_valid}, 64'd1);
    endtask

    // A new delivery is a valid output after an edge that was unstalled or that followed invalid.
    logic v_rec = 1'b0;
    logic s_rec = 1'b0;
    logic [ADDR_W+INST_W-1:0] e;
    always @(negedge clk) begin
        if (!rst && inst_valid && (!v_rec || !s_rec)) begin
            checks++;
            assert (exp_q.size() != 0)
            else begin
                failures++;
                $error("FAIL unexpected_delivery observed pc=%h expected none", pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                assert ({pc, inst} === e)
                else begin
                    failures++;
                    $error("FAIL scoreboard observed=%h expected=%h", {pc, inst}, e);
                end
            end
        end
        v_rec = inst_valid;
        s_rec = (ctrl_signal == 3'd1);
    end

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_addr", imem_addr, 64'h8000_0000);
        chk("rst_pc", pc, 64'd0);
        chk("rst_inst", {32'd0, inst}, 64'd0);
        chk("rst_valid", {63'd0, inst_valid}, 64'd0);

        // Sequential fetch
        rst      = 1'b0;
        imem_gnt = 1'b1;
        chk("idle_req", {63'd0, imem_req}, 64'd0);
        tick();
        serve(64'h8000_0000);
        serve(64'h8000_0004);

        // Stall at data return: skid, hold, then deliver
        chk("pre_stall_addr", imem_addr, 64'h8000_0008);
        tick();
        chk("wait_valid_clr", {63'd0, inst_valid}, 64'd0);
        ctrl_signal = 3'd1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0013;
        exp_q.push_back({64'h8000_0008, 32'h0000_0013});
        tick();
        imem_rvalid = 1'b0;
        chk("hold_req", {63'd0, imem_req}, 64'd0);
        chk("hold_valid", {63'd0, inst_valid}, 64'd0);
        chk("hold_pc", pc, 64'h8000_0004);
        tick();
        chk("hold2_req", {63'd0, imem_req}, 64'd0);
        ctrl_signal = 3'd0;
        tick();
        chk("skid_pc", pc, 64'h8000_0008);
        chk("skid_inst", {32'd0, inst}, 64'h13);
        chk("skid_valid", {63'd0, inst_valid}, 64'd1);
        chk("skid_next_addr", imem_addr, 64'h8000_000c);
        chk("skid_next_req", {63'd0, imem_req}, 64'd1);
        ctrl_signal = 3'd1;
        tick();
        chk("stall_keep_valid", {63'd0, inst_valid}, 64'd1);
        chk("stall_keep_pc", pc, 64'h8000_0008);
        ctrl_signal = 3'd0;
        imem_rvalid = 1'b1;
        imem_rdata  = data_of(64'h8000_000c);
        exp_q.push_back({64'h8000_000c, data_of(64'h8000_000c)});
        tick();
        imem_rvalid = 1'b0;
        chk("b2b_pc", pc, 64'h8000_000c);
        chk("b2b_addr", imem_addr, 64'h8000_0010);

        // Redirect in WAIT: stale data killed
        tick();
        redirect    = 1'b1;
        redirect_pc = 64'h8000_1000;
        tick();
        redirect = 1'b0;
        chk("kill_req", {63'd0, imem_req}, 64'd0);
        chk("kill_valid", {63'd0, inst_valid}, 64'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hdead_beef;
        tick();
        imem_rvalid = 1'b0;
        chk("stale_valid", {63'd0, inst_valid}, 64'd0);
        chk("stale_req", {63'd0, imem_req}, 64'd1);
        serve(64'h8000_1000);

        // Redirect in REQ without grant
        imem_gnt = 1'b0;
        tick();
        chk("nognt_addr", imem_addr, 64'h8000_1004);
        redirect    = 1'b1;
        redirect_pc = 64'h8000_2000;
        tick();
        redirect = 1'b0;
        chk("redir_req_addr", imem_addr, 64'h8000_2000);
        chk("redir_req_req", {63'd0, imem_req}, 64'd1);
        tick();
        tick();
        chk("redir_hold_addr", imem_addr, 64'h8000_2000);
        chk("redir_hold_valid", {63'd0, inst_valid}, 64'd0);
        serve(64'h8000_2000);

        // Redirect together with stall and rvalid
        tick();
        ctrl_signal = 3'd1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0bad_f00d;
        redirect    = 1'b1;
        redirect_pc = 64'h8000_3000;
        tick();
        ctrl_signal = 3'd0;
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        chk("coinc_valid", {63'd0, inst_valid}, 64'd0);
        chk("coinc_req", {63'd0, imem_req}, 64'd1);
        chk("coinc_addr", imem_addr, 64'h8000_3000);
        serve(64'h8000_3000);

        // Reset while waiting, with rvalid arriving during reset
        tick();
        rst         = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_2222;
        #1;
        chk("arst_valid", {63'd0, inst_valid}, 64'd0);
        chk("arst_pc", pc, 64'd0);
        chk("arst_addr", imem_addr, 64'h8000_0000);
        tick();
        chk("rst_rv_req", {63'd0, imem_req}, 64'd0);
        chk("rst_rv_inst", {32'd0, inst}, 64'd0);
        chk("rst_rv_valid", {63'd0, inst_valid}, 64'd0);
        rst         = 1'b0;
        imem_rvalid = 1'b0;
        tick();
        serve(64'h8000_0000);

        // PC wrap
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 64'hffff_ffff_ffff_fffc;
        tick();
        redirect = 1'b0;
        chk("wrap_addr", imem_addr, 64'hffff_ffff_ffff_fffc);
        serve(64'hffff_ffff_ffff_fffc);
        chk("wrap_next_addr", imem_addr, 64'd0);
        serve(64'd0);

        imem_gnt = 1'b0;
        tick();
        tick();
        tick();
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
